// File: rtl/param_cpu.sv
// Parameterised multicycle CPU: 8 x DATA_W register bank, Z/C flags, FSM sequencer.
// Define PARAM_CPU_CALL_EN to add CALL/RET using r7 as a descending stack pointer.
module param_cpu #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] address,
    output logic              memwt,
    output logic              halted
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_LDI,
        S_LD,
        S_ST,
        S_JUMP,
        S_ALU,
`ifdef PARAM_CPU_CALL_EN
        S_PUSH,
        S_POP,
`endif
        S_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
    localparam logic [DATA_W:0]   WIDE_ONE = (DATA_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic              z_q, z_d, c_q, c_d;

    logic [2:0]        alu_op, src_a, src_b, dst;
    logic [DATA_W-1:0] op_a, op_b, off_ext;
    logic [ADDR_W-1:0] jump_pc;
    logic [DATA_W:0]   alu_wide;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;

    assign alu_op  = ir_q[11:9];
    assign src_a   = ir_q[8:6];
    assign src_b   = ir_q[5:3];
    assign dst     = ir_q[2:0];
    assign op_a    = regs_q[src_a];
    assign op_b    = regs_q[src_b];
    // pc has already been incremented past the jump word when this is used
    assign off_ext = {{(DATA_W-12){ir_q[11]}}, ir_q[11:0]};
    assign jump_pc = pc_q + off_ext[ADDR_W-1:0];

`ifdef PARAM_CPU_CALL_EN
    logic [DATA_W-1:0] sp_dec;
    assign sp_dec = regs_q[7] - DATA_W'(1);
`endif

    always_comb begin
        alu_wide = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        case (alu_op)
            3'd0: begin
                alu_wide = {1'b0, op_a} + {1'b0, op_b};
                alu_res  = alu_wide[DATA_W-1:0];
                alu_c    = alu_wide[DATA_W];
            end
            3'd1: begin
                alu_wide = {1'b0, op_a} - {1'b0, op_b};
                alu_res  = alu_wide[DATA_W-1:0];
                alu_c    = alu_wide[DATA_W];
            end
            3'd2: alu_res = op_a & op_b;
            3'd3: alu_res = op_a | op_b;
            3'd4: alu_res = op_a ^ op_b;
            3'd5: begin
                alu_res = {op_a[DATA_W-2:0], 1'b0};
                alu_c   = op_a[DATA_W-1];
            end
            3'd6: begin
                alu_res = {1'b0, op_a[DATA_W-1:1]};
                alu_c   = op_a[0];
            end
            default: begin
                // unary group on B, sub-operation chosen by the srcA field
                case (src_a)
                    3'd0: alu_res = ~op_b;
                    3'd1: alu_res = op_b;
                    3'd2: begin
                        alu_wide = {1'b0, op_b} + WIDE_ONE;
                        alu_res  = alu_wide[DATA_W-1:0];
                        alu_c    = alu_wide[DATA_W];
                    end
                    3'd3: begin
                        alu_wide = {1'b0, op_b} - WIDE_ONE;
                        alu_res  = alu_wide[DATA_W-1:0];
                        alu_c    = alu_wide[DATA_W];
                    end
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        regs_d   = regs_q;
        z_d      = z_q;
        c_d      = c_q;
        address  = pc_q;
        data_out = '0;
        memwt    = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d = data_in[15:0];
                    pc_d = pc_q + PC_ONE;
                    case (data_in[15:12])
                        4'h1:    state_d = S_LDI;
                        4'h2:    state_d = S_LD;
                        4'h3:    state_d = S_ST;
                        4'h4:    state_d = z_q ? S_JUMP : S_FETCH;
                        4'h5:    state_d = S_JUMP;
                        4'h6:    state_d = c_q ? S_JUMP : S_FETCH;
                        4'h7:    state_d = S_ALU;
`ifdef PARAM_CPU_CALL_EN
                        4'h8:    state_d = S_PUSH;
                        4'h9:    state_d = S_POP;
`endif
                        4'hF:    state_d = S_HALT;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_LDI: begin
                if (mem_ready) begin
                    regs_d[dst] = data_in;
                    pc_d        = pc_q + PC_ONE;
                    state_d     = S_FETCH;
                end
            end
            S_LD: begin
                address = op_b[ADDR_W-1:0];
                if (mem_ready) begin
                    regs_d[dst] = data_in;
                    state_d     = S_FETCH;
                end
            end
            S_ST: begin
                address  = op_b[ADDR_W-1:0];
                data_out = op_a;
                memwt    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = jump_pc;
                state_d = S_FETCH;
            end
            S_ALU: begin
                regs_d[dst] = alu_res;
                z_d         = (alu_res == '0);
                c_d         = alu_c;
                state_d     = S_FETCH;
            end
`ifdef PARAM_CPU_CALL_EN
            S_PUSH: begin
                address  = sp_dec[ADDR_W-1:0];
                data_out = DATA_W'(pc_q);
                memwt    = 1'b1;
                if (mem_ready) begin
                    regs_d[7] = sp_dec;
                    pc_d      = jump_pc;
                    state_d   = S_FETCH;
                end
            end
            S_POP: begin
                address = regs_q[7][ADDR_W-1:0];
                if (mem_ready) begin
                    pc_d      = data_in[ADDR_W-1:0];
                    regs_d[7] = regs_q[7] + DATA_W'(1);
                    state_d   = S_FETCH;
                end
            end
`endif
            S_HALT:  halted = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
            for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
        end
    end

endmodule

// File: tb/tb_param_cpu.sv
// Bench for param_cpu: directed program scenarios plus random programs against an ISA-level model.
module tb_param_cpu;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int MEM_N  = 4096;
    localparam longint MOD = 64'd1 << DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_ready = 1'b0;
    logic [DATA_W-1:0] data_in, data_out;
    logic [ADDR_W-1:0] address;
    logic              memwt, halted;

    logic [DATA_W-1:0] mem [MEM_N];
    logic [DATA_W-1:0] mm  [MEM_N];
    logic [15:0]       prog [$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    assign data_in = mem[address];

    param_cpu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .mem_ready(mem_ready),
        .data_out(data_out), .address(address), .memwt(memwt), .halted(halted)
    );

    function automatic logic [15:0] i_ldi(input logic [2:0] d);
        return {4'h1, 9'd0, d};
    endfunction
    function automatic logic [15:0] i_ld(input logic [2:0] b, input logic [2:0] d);
        return {4'h2, 6'd0, b, d};
    endfunction
    function automatic logic [15:0] i_st(input logic [2:0] a, input logic [2:0] b);
        return {4'h3, 3'd0, a, b, 3'd0};
    endfunction
    function automatic logic [15:0] i_alu(input logic [2:0] op, input logic [2:0] a,
                                          input logic [2:0] b, input logic [2:0] d);
        return {4'h7, op, a, b, d};
    endfunction
    function automatic logic [15:0] i_jmp(input logic [3:0] opc, input logic [11:0] off);
        return {opc, off};
    endfunction
    function automatic logic [15:0] rv();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic put_ldi(input logic [2:0] d, input logic [15:0] v);
        prog.push_back(i_ldi(d));
        prog.push_back(v);
    endtask

    // Z -> mem[0x806], C -> mem[0x807], r0..r5 -> mem[0x800..0x805], then HALT
    task automatic put_dump();
        put_ldi(3'd6, 16'h0001);
        prog.push_back(i_jmp(4'h4, 12'd2));
        put_ldi(3'd6, 16'h0000);
        put_ldi(3'd7, 16'h0806);
        prog.push_back(i_st(3'd6, 3'd7));
        put_ldi(3'd6, 16'h0001);
        prog.push_back(i_jmp(4'h6, 12'd2));
        put_ldi(3'd6, 16'h0000);
        put_ldi(3'd7, 16'h0807);
        prog.push_back(i_st(3'd6, 3'd7));
        for (int k = 0; k < 6; k++) begin
            put_ldi(3'd7, 16'h0800 + 16'(k));
            prog.push_back(i_st(3'(k), 3'd7));
        end
        prog.push_back(16'hF000);
    endtask

    task automatic load_prog(input bit rand_data);
        for (int i = 0; i < MEM_N; i++) mem[i] = '0;
        if (rand_data)
            for (int i = 12'hC00; i < 12'hC40; i++) mem[i] = rv();
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
        mm = mem;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one clock: present mem_ready, commit any write the core is strobing, advance to next negedge
    task automatic step(input logic rdy);
        mem_ready = rdy;
        #1;
        if (memwt && mem_ready) mem[address] = data_out;
        @(negedge clk);
    endtask

    task automatic dut_run(input bit rand_ready, output int cyc, output bit timed_out);
        cyc = 0;
        timed_out = 1'b1;
        do_reset();
        for (int k = 0; k < 5000; k++) begin
            step(rand_ready ? logic'($urandom_range(0, 3) != 0) : 1'b1);
            cyc++;
            if (halted) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // instruction-level reference: executes mm[] and counts cycles from the latency rules
    task automatic model_run(output int cyc);
        int pc, off, a_i;
        longint r [8];
        longint a, b, res;
        bit z, c, cf, taken;
        logic [15:0] ir;
        logic [3:0] opc;
        logic [2:0] aop, sa, sb, d;
        pc = 0; z = 0; c = 0; cyc = 0;
        for (int i = 0; i < 8; i++) r[i] = 0;
        for (int s = 0; s < 3000; s++) begin
            ir = mm[pc];
            pc = (pc + 1) % MEM_N;
            opc = ir[15:12]; aop = ir[11:9]; sa = ir[8:6]; sb = ir[5:3]; d = ir[2:0];
            off = int'(ir[11:0]);
            if (ir[11]) off -= 4096;
            case (opc)
                4'h1: begin r[d] = mm[pc]; pc = (pc + 1) % MEM_N; cyc += 2; end
                4'h2: begin r[d] = mm[int'(r[sb] % MEM_N)]; cyc += 2; end
                4'h3: begin mm[int'(r[sb] % MEM_N)] = DATA_W'(r[sa]); cyc += 2; end
                4'h4, 4'h5, 4'h6: begin
                    taken = (opc == 4'h5) || (opc == 4'h4 && z) || (opc == 4'h6 && c);
                    if (taken) begin
                        pc = ((pc + off) % MEM_N + MEM_N) % MEM_N;
                        cyc += 2;
                    end else cyc += 1;
                end
                4'h7: begin
                    a = r[sa]; b = r[sb]; cf = 0; res = 0;
                    case (aop)
                        3'd0: begin res = a + b; cf = res >= MOD; res = res % MOD; end
                        3'd1: begin cf = a < b; res = (a - b + MOD) % MOD; end
                        3'd2: res = a & b;
                        3'd3: res = a | b;
                        3'd4: res = a ^ b;
                        3'd5: begin cf = a >= MOD / 2; res = (a * 2) % MOD; end
                        3'd6: begin cf = (a % 2) == 1; res = a / 2; end
                        default: begin
                            case (sa)
                                3'd0: res = MOD - 1 - b;
                                3'd1: res = b;
                                3'd2: begin res = (b + 1) % MOD; cf = (b == MOD - 1); end
                                3'd3: begin res = (b + MOD - 1) % MOD; cf = (b == 0); end
                                default: res = 0;
                            endcase
                        end
                    endcase
                    r[d] = res; z = (res == 0); c = cf; cyc += 2;
                end
`ifdef PARAM_CPU_CALL_EN
                4'h8: begin
                    r[7] = (r[7] + MOD - 1) % MOD;
                    mm[int'(r[7] % MEM_N)] = DATA_W'(pc);
                    pc = ((pc + off) % MEM_N + MEM_N) % MEM_N;
                    cyc += 2;
                end
                4'h9: begin
                    a_i = int'(r[7] % MEM_N);
                    pc = int'(mm[a_i]) % MEM_N;
                    r[7] = (r[7] + 1) % MOD;
                    cyc += 2;
                end
`endif
                4'hF: begin cyc += 1; break; end
                default: cyc += 1;
            endcase
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({address, memwt, halted} !== '0)
            $display("FAIL reset_ctrl: got addr=%h memwt=%b halted=%b required 0/0/0", address, memwt, halted);
        checks++;
        if (data_out !== '0)
            $display("FAIL reset_data_out: got %h required 0000", data_out);
        failures = failures + ((({address, memwt, halted} !== '0) ? 1 : 0) + ((data_out !== '0) ? 1 : 0));
        $display("test_reset done");
    endtask

    task automatic test_sub();
        int cyc, mcyc;
        bit to;
        prog.delete();
        put_ldi(3'd1, 16'h0005); put_ldi(3'd2, 16'h0003);
        prog.push_back(i_alu(3'd1, 3'd1, 3'd2, 3'd3));
        prog.push_back(16'hF000);
        load_prog(0);
        dut_run(0, cyc, to);
        checks++;
        if (to || cyc != 7) begin failures++; $display("FAIL sub_cycles: got %0d (timeout=%0d) required 7", cyc, to); end
        prog.delete();
        put_ldi(3'd1, 16'h0005); put_ldi(3'd2, 16'h0003);
        prog.push_back(i_alu(3'd1, 3'd1, 3'd2, 3'd3));
        put_dump();
        load_prog(0);
        model_run(mcyc);
        dut_run(0, cyc, to);
        checks++;
        if ({mem[12'h803], mem[12'h806], mem[12'h807]} !== {16'h0002, 16'h0000, 16'h0000}) begin
            failures++;
            $display("FAIL sub_result: got r3=%h Z=%h C=%h required 0002/0000/0000", mem[12'h803], mem[12'h806], mem[12'h807]);
        end
        checks++;
        if (cyc != mcyc) begin failures++; $display("FAIL sub_dump_cycles: got %0d required %0d", cyc, mcyc); end
        $display("test_sub cycles=%0d", cyc);
    endtask

    task automatic test_jz();
        int cyc, mcyc;
        bit to;
        prog.delete();
        put_ldi(3'd1, 16'h0007); put_ldi(3'd2, 16'h0007);
        prog.push_back(i_alu(3'd1, 3'd1, 3'd2, 3'd3));
        prog.push_back(i_jmp(4'h4, 12'hFFD));
        prog.push_back(16'hF000);
        load_prog(0);
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b1);
        checks++;
        if (address !== 12'h003) begin failures++; $display("FAIL jz_taken_target: got %h required 003", address); end
        prog.delete();
        put_ldi(3'd1, 16'h0007); put_ldi(3'd2, 16'h0008);
        prog.push_back(i_alu(3'd1, 3'd1, 3'd2, 3'd3));
        prog.push_back(i_jmp(4'h4, 12'hFFD));
        put_dump();
        load_prog(0);
        do_reset();
        for (int k = 0; k < 7; k++) step(1'b1);
        checks++;
        if (address !== 12'h006) begin failures++; $display("FAIL jz_fallthrough: got %h required 006", address); end
        model_run(mcyc);
        dut_run(0, cyc, to);
        checks++;
        if ({mem[12'h803], mem[12'h806], mem[12'h807]} !== {16'hFFFF, 16'h0000, 16'h0001} || cyc != mcyc) begin
            failures++;
            $display("FAIL jz_borrow: got r3=%h Z=%h C=%h cyc=%0d required FFFF/0000/0001 cyc=%0d",
                     mem[12'h803], mem[12'h806], mem[12'h807], cyc, mcyc);
        end
        $display("test_jz cycles=%0d", cyc);
    endtask

    task automatic test_st_wait();
        prog.delete();
        put_ldi(3'd4, 16'hBEEF); put_ldi(3'd5, 16'h0040);
        prog.push_back(i_st(3'd4, 3'd5));
        prog.push_back(16'hF000);
        load_prog(0);
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1);
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (memwt !== 1'b1 || address !== 12'h040 || data_out !== 16'hBEEF) begin
                failures++;
                $display("FAIL st_hold_%0d: got memwt=%b addr=%h data=%h required 1/040/BEEF", w, memwt, address, data_out);
            end
            step(w == 3);
        end
        checks++;
        if (memwt !== 1'b0 || address !== 12'h005 || mem[12'h040] !== 16'hBEEF) begin
            failures++;
            $display("FAIL st_done: got memwt=%b addr=%h mem40=%h required 0/005/BEEF", memwt, address, mem[12'h040]);
        end
        step(1'b1);
        checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL st_halt: got %b required 1", halted); end
        $display("test_st_wait done");
    endtask

    task automatic test_alu_edges();
        int cyc;
        bit to;
        prog.delete();
        put_ldi(3'd1, 16'hFFFF); put_ldi(3'd2, 16'h0001);
        prog.push_back(i_alu(3'd0, 3'd1, 3'd2, 3'd3));
        put_dump();
        load_prog(0);
        dut_run(0, cyc, to);
        checks++;
        if ({mem[12'h803], mem[12'h806], mem[12'h807]} !== {16'h0000, 16'h0001, 16'h0001}) begin
            failures++;
            $display("FAIL add_wrap: got r=%h Z=%h C=%h required 0000/0001/0001", mem[12'h803], mem[12'h806], mem[12'h807]);
        end
        prog.delete();
        put_ldi(3'd1, 16'h0001);
        prog.push_back(i_alu(3'd6, 3'd1, 3'd0, 3'd3));
        put_dump();
        load_prog(0);
        dut_run(0, cyc, to);
        checks++;
        if ({mem[12'h803], mem[12'h806], mem[12'h807]} !== {16'h0000, 16'h0001, 16'h0001}) begin
            failures++;
            $display("FAIL shr_lsb: got r=%h Z=%h C=%h required 0000/0001/0001", mem[12'h803], mem[12'h806], mem[12'h807]);
        end
        $display("test_alu_edges done");
    endtask

    task automatic test_reset_mid_ld();
        prog.delete();
        put_ldi(3'd1, 16'h1234); put_ldi(3'd5, 16'h0100);
        prog.push_back(i_ld(3'd5, 3'd2));
        prog.push_back(16'hF000);
        load_prog(0);
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1);
        step(1'b0); step(1'b0);
        checks++;
        if (address !== 12'h100) begin failures++; $display("FAIL ld_wait_addr: got %h required 100", address); end
        rst = 1'b1;
        #1;
        checks++;
        if (address !== '0 || memwt !== 1'b0 || data_out !== '0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL ld_reset_abort: got addr=%h memwt=%b data=%h halted=%b required 0", address, memwt, data_out, halted);
        end
        prog.delete();
        for (int k = 0; k < 8; k++) prog.push_back(i_st(3'(k), 3'd0));
        prog.push_back(16'hF000);
        load_prog(0);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (address !== '0) begin failures++; $display("FAIL first_fetch: got %h required 000", address); end
        for (int k = 0; k < 8; k++) begin
            step(1'b1);
            checks++;
            if (memwt !== 1'b1 || address !== '0 || data_out !== '0) begin
                failures++;
                $display("FAIL reg_cleared_r%0d: got memwt=%b addr=%h data=%h required 1/000/0000", k, memwt, address, data_out);
            end
            step(1'b1);
        end
        $display("test_reset_mid_ld done");
    endtask

    task automatic test_call_ret();
        for (int i = 0; i < MEM_N; i++) mem[i] = '0;
        mem[0] = i_ldi(3'd7); mem[1] = 16'h0100;
        mem[2] = i_jmp(4'h5, 12'h01D);
        mem[12'h020] = 16'h8010;
`ifdef PARAM_CPU_CALL_EN
        mem[12'h021] = i_st(3'd7, 3'd0);
        mem[12'h022] = 16'hF000;
        mem[12'h031] = 16'h9000;
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1);
        step(1'b1);
        checks++;
        if (memwt !== 1'b1 || address !== 12'h0FF || data_out !== 16'h0021) begin
            failures++;
            $display("FAIL call_push: got memwt=%b addr=%h data=%h required 1/0FF/0021", memwt, address, data_out);
        end
        step(1'b1);
        checks++;
        if (address !== 12'h031 || mem[12'h0FF] !== 16'h0021) begin
            failures++;
            $display("FAIL call_target: got addr=%h mem0FF=%h required 031/0021", address, mem[12'h0FF]);
        end
        step(1'b1); step(1'b1);
        checks++;
        if (address !== 12'h021) begin failures++; $display("FAIL ret_target: got %h required 021", address); end
        step(1'b1); step(1'b1);
        checks++;
        if (mem[0] !== 16'h0100) begin failures++; $display("FAIL ret_sp: got r7=%h required 0100", mem[0]); end
`else
        mem[12'h021] = 16'h9000;
        mem[12'h022] = i_st(3'd7, 3'd0);
        mem[12'h023] = 16'hF000;
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1);
        step(1'b1);
        checks++;
        if (address !== 12'h021 || memwt !== 1'b0) begin
            failures++;
            $display("FAIL call_nop: got addr=%h memwt=%b required 021/0", address, memwt);
        end
        step(1'b1);
        checks++;
        if (address !== 12'h022) begin failures++; $display("FAIL ret_nop: got %h required 022", address); end
        step(1'b1); step(1'b1);
        checks++;
        if (mem[0] !== 16'h0100 || mem[12'h0FF] !== 16'h0000) begin
            failures++;
            $display("FAIL nop_sp: got r7=%h mem0FF=%h required 0100/0000", mem[0], mem[12'h0FF]);
        end
`endif
        step(1'b1);
        checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL call_halt: got %b required 1", halted); end
        $display("test_call_ret done");
    endtask

    task automatic test_random();
        int cyc, mcyc, nbad, first;
        bit to, rr;
        logic [ADDR_W-1:0] hold_addr;
        for (int p = 0; p < 10; p++) begin
            rr = p[0];
            prog.delete();
            for (int k = 0; k < 8; k++) put_ldi(3'(k), rv());
            for (int n = 0; n < 40; n++) begin
                case ($urandom_range(0, 9))
                    0, 1: put_ldi(3'($urandom), rv());
                    2, 3, 4: prog.push_back(i_alu(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom)));
                    5: begin
                        put_ldi(3'd7, 16'h0C00 + 16'($urandom_range(0, 63)));
                        prog.push_back(i_st(3'($urandom), 3'd7));
                    end
                    6: begin
                        put_ldi(3'd7, 16'h0C00 + 16'($urandom_range(0, 63)));
                        prog.push_back(i_ld(3'd7, 3'($urandom)));
                    end
                    7: begin
                        prog.push_back(i_jmp(4'($urandom_range(4, 6)), 12'($urandom_range(0, 1))));
                        prog.push_back(i_alu(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom)));
                    end
                    8: begin
`ifdef PARAM_CPU_CALL_EN
                        prog.push_back({4'($urandom_range(10, 14)), 12'($urandom)});
`else
                        prog.push_back({4'($urandom_range(8, 14)), 12'($urandom)});
`endif
                        prog.push_back(16'h0000);
                    end
                    default: prog.push_back(i_alu(3'd7, 3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom)));
                endcase
            end
            put_dump();
            load_prog(1);
            model_run(mcyc);
            dut_run(rr, cyc, to);
            checks++;
            if (to) begin failures++; $display("FAIL rand_%0d_halt: no halt within 5000 cycles", p); end
            if (!rr) begin
                checks++;
                if (cyc != mcyc) begin failures++; $display("FAIL rand_%0d_cycles: got %0d required %0d", p, cyc, mcyc); end
            end
            nbad = 0; first = 0;
            for (int i = 0; i < MEM_N; i++)
                if (mem[i] !== mm[i]) begin
                    if (nbad == 0) first = i;
                    nbad++;
                end
            checks++;
            if (nbad != 0) begin
                failures++;
                $display("FAIL rand_%0d_mem: %0d words differ, first [%h] got %h required %h", p, nbad, first, mem[first], mm[first]);
            end
            hold_addr = address;
            step(1'b1); step(1'b1); step(1'b1);
            checks++;
            if (halted !== 1'b1 || memwt !== 1'b0 || address !== hold_addr) begin
                failures++;
                $display("FAIL rand_%0d_hold: got halted=%b memwt=%b addr=%h required 1/0/%h", p, halted, memwt, address, hold_addr);
            end
            $display("random program %0d ready_random=%0d words=%0d cycles=%0d", p, rr, prog.size(), cyc);
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_jz();
        test_st_wait();
        test_alu_edges();
        test_reset_mid_ld();
        test_call_ret();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_cpu.md
PARAM_CPU -- requirements
Module: param_cpu

Interface
REQ-001 Parameter DATA_W, default 16: register and data bus width, legal 16..32.
REQ-002 Parameter ADDR_W, default 12: address and program counter width, legal 8..DATA_W.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port data_in, input, DATA_W: memory read data; instruction word in bits [15:0].
REQ-006 Port mem_ready, input, 1: memory completes the current access this cycle when high.
REQ-007 Port data_out, output, DATA_W: store data.
REQ-008 Port address, output, ADDR_W: memory address.
REQ-009 Port memwt, output, 1: write strobe.
REQ-010 Port halted, output, 1: core stopped by HALT.

Function
REQ-011 The instruction format SHALL be: opcode [15:12], alu-op [11:9], srcA [8:6], srcB [5:3], dst [2:0], jump offset [11:0] signed; the bank holds 8 registers r0..r7 of DATA_W bits.
REQ-012 The FSM states SHALL be FETCH, LDI, LD, ST, JUMP, ALU, PUSH, POP, HALT; opcodes: 0 NOP, 1 LDI, 2 LD, 3 ST, 4 JZ, 5 JMP, 6 JC, 7 ALU, 8 CALL, 9 RET, F HALT; all others execute as NOP.
REQ-013 FETCH SHALL drive address=pc and wait while mem_ready=0; on mem_ready=1 it SHALL latch ir, increment pc modulo 2^ADDR_W, and go to the opcode's state; NOP returns to FETCH.
REQ-014 JZ/JC SHALL go to JUMP only if flag Z/C is 1, else to FETCH; JMP always goes to JUMP.
REQ-015 JUMP SHALL set pc <= pc + sign-extended offset (pc already incremented), wrapping modulo 2^ADDR_W, in one cycle, with no memory access.
REQ-016 LDI SHALL read the word at pc into r[dst] and increment pc; LD SHALL read address r[srcB][ADDR_W-1:0] into r[dst]; both wait on mem_ready.
REQ-017 ST SHALL drive address=r[srcB][ADDR_W-1:0], data_out=r[srcA] and memwt=1 until mem_ready=1, then go to FETCH; memwt SHALL be 0 in every other state.
REQ-018 ALU SHALL write result to r[dst] and update Z=(result==0) and C in one cycle: 0 ADD (C=carry), 1 SUB A-B (C=borrow), 2 AND, 3 OR, 4 XOR, 5 SHL A by 1 (C=old MSB), 6 SHR A by 1 logical (C=old LSB), 7 unary on B selected by srcA field: 0 bitwise NOT, 1 MOV, 2 INC, 3 DEC (C=carry/borrow), others result 0; logic ops clear C.
REQ-019 Z and C SHALL be dedicated flag bits, not part of any register; non-ALU instructions SHALL leave them unchanged.
REQ-020 HALT state SHALL assert halted=1, hold all state, and exit only on reset.
REQ-021 With mem_ready held 1, latency SHALL be 2 cycles for every instruction except NOP, untaken jumps and HALT entry (1 cycle).
REQ-022 Where ALU dst and a following instruction's source coincide, the following instruction SHALL see the written value (no hazard; multicycle).

Reset
REQ-023 rst=1 SHALL immediately force state=FETCH, pc=0, ir=0, r0..r7=0, Z=C=0, halted=0, memwt=0, address=0, data_out=0.
REQ-024 Reset asserted mid-access (including ST with memwt=1) SHALL abort the access in the same cycle; the first fetch after release SHALL be from address 0.

Configuration
REQ-025 With macro PARAM_CPU_CALL_EN defined, r7 SHALL serve as stack pointer: CALL goes to PUSH (address=r7-1, data_out=pc, memwt=1 until mem_ready; then r7<=r7-1, pc<=pc+offset); RET goes to POP (address=r7, read until mem_ready; then pc<=data_in[ADDR_W-1:0], r7<=r7+1).
REQ-026 Without PARAM_CPU_CALL_EN, opcodes 8 and 9 SHALL execute as NOP and PUSH/POP logic SHALL be absent.

Verification
REQ-027 Program LDI r1,0x0005; LDI r2,0x0003; SUB r3=r1-r2 -> r3=0x0002, Z=0, C=0, total 6 cycles with mem_ready=1.
REQ-028 r1=r2=0x0007, SUB then JZ offset -3 -> Z=1, pc jumps back 3 words; with r2=0x0008 -> C=1, Z=0, JZ falls through.
REQ-029 ST r4->[r5=0x0040] with mem_ready low 3 cycles -> memwt=1 and address=0x040 held 4 cycles, data_out=r4, then FETCH.
REQ-030 DATA_W=16: ADD 0xFFFF+0x0001 -> r=0x0000, Z=1, C=1; SHR 0x0001 -> 0x0000, C=1.
REQ-031 rst pulsed during LD wait state -> all registers 0, next address 0x000, halted=0.
REQ-032 PARAM_CPU_CALL_EN defined, r7=0x100, CALL +0x10 at pc 0x020 -> mem[0x0FF]=0x021, r7=0x0FF, pc=0x031; RET -> pc=0x021, r7=0x100; undefined -> both NOP.
